// File: rtl/input_conditioner.sv
// input_conditioner: N-channel button front end with sync, debounce, edge pulses and hold-to-repeat
module input_conditioner #(
  parameter int N_CH = 3,
  parameter int DB_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY = 30_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter logic [N_CH-1:0] INVERT = '0
) (
  input  logic            clk_100MHz,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_rise,
  output logic [N_CH-1:0] btn_fall,
  output logic [N_CH-1:0] btn_repeat
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
  typedef enum logic [1:0] {IDLE, DELAY, RPT} rstate_e;
  if (DB_CYCLES < 1 || REPEAT_PERIOD < 1 || N_CH < 1) begin : g_bad_params
    $error("input_conditioner: DB_CYCLES, REPEAT_PERIOD and N_CH must all be >= 1");
  end
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic s1_q, s1_d, s2_q, s2_d, flip;
    logic level_q, level_d, rise_q, rise_d, fall_q, fall_d, rep_q, rep_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    rstate_e state_q, state_d;
    always_comb begin
      s1_d = btn_in[c] ^ INVERT[c];
      s2_d = s1_q;
      flip = (s2_q != level_q) && (cnt_q == DB_LAST);
      cnt_d = (s2_q == level_q || flip) ? '0 : cnt_q + 1'b1;
      level_d = flip ? s2_q : level_q;
      rise_d = flip & s2_q;
      fall_d = flip & ~s2_q;
      state_d = state_q;
      rcnt_d = rcnt_q + 1'b1;
      rep_d = 1'b0;
      // a release always wins over a repeat falling due in the same cycle
      if (fall_d) begin
        state_d = IDLE;
        rcnt_d = '0;
      end else if (rise_d) begin
        rep_d = 1'b1;
        state_d = (REPEAT_DELAY == 0) ? IDLE : DELAY;
        rcnt_d = '0;
      end else if (state_q == DELAY && rcnt_q == DELAY_LAST) begin
        rep_d = 1'b1;
        state_d = RPT;
        rcnt_d = '0;
      end else if (state_q == RPT && rcnt_q == PERIOD_LAST) begin
        rep_d = 1'b1;
        rcnt_d = '0;
      end else if (state_q == IDLE) begin
        rcnt_d = '0;
      end
    end
    always_ff @(posedge clk_100MHz) begin
      if (reset) begin
        s1_q <= 1'b0;
        s2_q <= 1'b0;
        cnt_q <= '0;
        level_q <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        rep_q <= 1'b0;
        rcnt_q <= '0;
        state_q <= IDLE;
      end else begin
        s1_q <= s1_d;
        s2_q <= s2_d;
        cnt_q <= cnt_d;
        level_q <= level_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
        rep_q <= rep_d;
        rcnt_q <= rcnt_d;
        state_q <= state_d;
      end
    end
    assign btn_level[c] = level_q;
    assign btn_rise[c] = rise_q;
    assign btn_fall[c] = fall_q;
    assign btn_repeat[c] = rep_q;
  end
endmodule
